// File: rtl/key_schedule_dec.sv
// DES decryption key schedule.
// Walks the encryption schedule backwards: it loads the PC1-permuted key, then
// emits K16 down to K1, one key per accepted handshake. The C/D halves rotate
// right between keys, so no key storage is needed.
//
// Handshake: k is offered while k_valid is high. It is consumed on a rising
// edge where k_valid && k_ready. While k_valid && !k_ready, k, idx and r stay
// stable. k_ready has no effect while k_valid is low.

// PC2 permutation: selects 48 of the 56 {C,D} bits.
// Input bit n of the DES table maps to cd[56-n].
module perm_pc2 (
  input  logic [55:0] cd,
  output logic [47:0] k
);
  assign k = {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
              cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
              cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
              cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
              cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
              cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
              cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
              cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
endmodule

module key_schedule_dec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [55:0] x,
  output logic        busy,
  output logic        k_valid,
  input  logic        k_ready,
  output logic [47:0] k,
  output logic [3:0]  idx,
  output logic [55:0] r,
  output logic        done
);

  typedef enum logic {IDLE, GEN} state_t;

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        one_step;

  // Encryption rounds 1, 2, 9 and 16 shift by one. Here that is idx 15, 8 and 1.
  // idx 0 never rotates.
  assign one_step = (idx_q == 4'd15) || (idx_q == 4'd8) || (idx_q == 4'd1);

  // Next-state logic. The total encryption rotation is 28, which is the identity.
  // So the loaded key is already {C16,D16}.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d     = x[55:28];
          d_d     = x[27:0];
          idx_d   = 4'd15;
          state_d = GEN;
        end
      end
      GEN: begin
        if (k_ready) begin
          if (idx_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            if (one_step) begin
              c_d = {c_q[0], c_q[27:1]};
              d_d = {d_q[0], d_q[27:1]};
            end else begin
              c_d = {c_q[1:0], c_q[27:2]};
              d_d = {d_q[1:0], d_q[27:2]};
            end
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == GEN);
  assign k_valid = (state_q == GEN);
  assign idx     = idx_q;
  assign r       = {c_q, d_q};
  assign done    = done_q;

  perm_pc2 u_pc2 (
    .cd (r),
    .k  (k)
  );

endmodule

// File: tb/tb_key_schedule_dec.sv
// Testbench for key_schedule_dec.
// The reference model runs the forward DES encryption schedule with left
// rotations and the PC2 table. It queues the keys in reverse round order.
// A monitor pops one entry from the queue for every accepted key.
module tb_key_schedule_dec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [55:0] x;
  logic        busy;
  logic        k_valid;
  logic        k_ready;
  logic [47:0] k;
  logic [3:0]  idx;
  logic [55:0] r;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic        rand_ready = 1'b0;
  logic [47:0] last_k0 = '0;
  logic [107:0] exp_q[$];

  localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;

  // DES PC2 table, 1-based from the MSB of the 56-bit {C,D} word.
  localparam int PC2_TAB[48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Left-shift amount for each encryption round, 1..16.
  localparam int SHIFTS[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  key_schedule_dec dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x       (x),
    .busy    (busy),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .k       (k),
    .idx     (idx),
    .r       (r),
    .done    (done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pc2_ref(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_TAB[i]];
    return o;
  endfunction

  // Computes the encryption round keys K1..K16 and queues them as K16 first.
  task automatic push_model(input logic [55:0] key);
    logic [27:0] c, d;
    logic [55:0] cds[16];
    c = key[55:28];
    d = key[27:0];
    for (int n = 0; n < 16; n++) begin
      c = (c << SHIFTS[n]) | (c >> (28 - SHIFTS[n]));
      d = (d << SHIFTS[n]) | (d >> (28 - SHIFTS[n]));
      cds[n] = {c, d};
    end
    for (int n = 15; n >= 0; n--) begin
      logic [3:0] ni;
      ni = 4'(n);
      exp_q.push_back({cds[n], ni, pc2_ref(cds[n])});
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer readiness: always ready, or a coin flip every cycle.
  always @(posedge clk) begin
    #1;
    k_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard, sampled on the falling edge.
  logic         exp_done = 1'b0;
  logic         prev_stall = 1'b0;
  logic [107:0] held = '0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", 128'(done), 128'(exp_done));
      if (prev_stall && k_valid) chk("stall_hold", 128'({r, idx, k}), 128'(held));
      if (k_valid && k_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL key_unexpected: got idx=%0d k=%h expected no key", idx, k);
        end else begin
          chk("key", 128'({r, idx, k}), 128'(exp_q.pop_front()));
        end
        if (idx == 4'd0) last_k0 = k;
      end
      exp_done   = k_valid && k_ready && (idx == 4'd0);
      prev_stall = k_valid && !k_ready;
      held       = {r, idx, k};
    end
  end

  // Driver: call #1 after a rising edge. Leaves the DUT #1 after the first GEN edge.
  task automatic start_seq(input logic [55:0] key);
    push_model(key);
    start = 1'b1;
    x     = key;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = 56'($urandom) ^ {24'($urandom), 32'h0};
    chk("first_valid", 128'({k_valid, busy, idx}), 128'({1'b1, 1'b1, 4'd15}));
  endtask

  // Returns #1 after the edge that raises done, or flags a timeout.
  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk);
      #1;
      if (done) break;
      cyc++;
    end
    if (cyc >= 400) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end else begin
      chk("done_cycle", 128'({busy, k_valid}), 128'(2'b00));
      chk("queue_drained", 128'(exp_q.size()), 128'(0));
    end
  endtask

  // Waits until idx reaches target while in GEN. Returns 0 on timeout.
  task automatic wait_idx(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      if (k_valid && idx == target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idx_timeout: got no idx=%0d expected it within 400 cycles", target);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    // Reset
    rst     = 1'b0;
    start   = 1'b0;
    x       = '0;
    k_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 128'({busy, k_valid, done, idx, k, r}), 128'(0));
    rst = 1'b1;
    idle_cycle();
    chk("idle_after_reset", 128'({busy, k_valid, done}), 128'(0));

    // 1: known vector, always ready
    start_seq(KEY_A);
    chk("k16", 128'(k), 128'(48'hCB3D8B0E17F5));
    idle_cycle();
    chk("k15", 128'({idx, k}), 128'({4'd14, 48'hBF918D3D3F0A}));
    wait_done();
    chk("k1", 128'(last_k0), 128'(48'h1B02EFFC7072));
    // The final halves equal the loaded key rotated left by one.
    chk("final_cd", 128'(r), 128'({KEY_A[54:28], KEY_A[55], KEY_A[26:0], KEY_A[27]}));
    idle_cycle();

    // 2: same key, random backpressure
    rand_ready = 1'b1;
    start_seq(KEY_A);
    wait_done();
    chk("k1_stall", 128'(last_k0), 128'(48'h1B02EFFC7072));
    rand_ready = 1'b0;
    idle_cycle();

    // 3: start with a different key in mid-sequence must be ignored
    start_seq(KEY_A);
    wait_idx(4'd9, ok);
    start = 1'b1;
    x     = 56'h123456789ABCDE;
    repeat (3) idle_cycle();
    start = 1'b0;
    wait_done();
    idle_cycle();

    // 4: asynchronous reset in mid-sequence, then restart
    start_seq(KEY_A);
    wait_idx(4'd7, ok);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", 128'({busy, k_valid, done, idx, k, r}), 128'(0));
    exp_q.delete();
    repeat (2) idle_cycle();
    rst = 1'b1;
    idle_cycle();
    chk("no_done_after_reset", 128'(done), 128'(0));
    start_seq(KEY_A);
    chk("restart_k16", 128'({idx, k}), 128'({4'd15, 48'hCB3D8B0E17F5}));
    wait_done();

    // 5: back-to-back, with start raised in the done cycle
    start_seq(KEY_A);
    wait_done();
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_seq({24'($urandom), 32'($urandom)});
      wait_done();
    end
    rand_ready = 1'b0;
    idle_cycle();

    // 6: constant halves
    start_seq(56'hFFFFFFFFFFFFFF);
    wait_done();
    idle_cycle();
    start_seq(56'h0000000FFFFFFF);
    wait_done();
    idle_cycle();

    chk("queue_empty_end", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_dec.md
Name: key_schedule_dec

Overview:
- Sequential DES decryption key schedule: emits the 16 round keys in reverse order, K16 first and K1 last, one key per accepted handshake.
- Input is the 56-bit PC1-permuted key (C in bits 55:28, D in bits 27:0).
- Rotates C/D halves right, the inverse of the encryption schedule, so the decryption datapath can consume keys on the fly without storing all 16.
- Sits between the key-load logic and the decryption round datapath; reuses the existing perm_PC2 block.

Parameters:
- none (DES widths and shift table are fixed)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  load request; sampled only in IDLE
- x  input  56  PC1-permuted key; C = x[55:28], D = x[27:0]
- busy  output  1  high from the cycle after an accepted start until the last key is accepted
- k_valid  output  1  k is a valid round key
- k_ready  input  1  consumer accepts k when k_valid && k_ready
- k  output  48  current round key, PC2(C,D)
- idx  output  4  encryption round number of k, minus one (15 down to 0)
- r  output  56  current {C,D} state feeding PC2
- done  output  1  one-cycle pulse after the final key (idx=0) is accepted

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; C, D, k, r = 0; idx = 0; busy, k_valid, done = 0. All outputs are registered or derived from registered state.
- States: IDLE, GEN.
- IDLE:
  - k_valid = 0, busy = 0.
  - start=1 loads C=x[55:28], D=x[27:0] unrotated, since the total encryption rotation is 28 ≡ identity, so {C0,D0} = {C16,D16}.
  - Same edge: idx = 15, move to GEN.
  - start=0: hold state.
- GEN:
  - busy = 1, k_valid = 1, k = PC2({C,D}) combinationally from registers, r = {C,D}.
  - Latency: first key valid on the cycle after start is sampled.
- Advance on a handshake (k_valid && k_ready) with idx>0:
  - C and D each rotate right by s, where s is the encryption shift amount of round idx+1.
  - Rotate by 1 when idx+1 ∈ {1,2,9,16}, otherwise by 2; so with idx = current value, s = 1 for idx ∈ {15,8,1}, else 2.
  - Then idx decrements by 1.
  - Rotate-right sequence applied between successive keys: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - 28-bit rotations wrap within each half; bits never cross between C and D.
- Handshake at idx=0: go to IDLE; done = 1 for exactly that next cycle; k_valid = 0; C/D retain their final value (equal to the loaded key rotated left by 1).
- Stall: k_valid=1 with k_ready=0 holds k, idx, r stable indefinitely.
- start is ignored while in GEN; it cannot restart or corrupt the sequence.
- start=1 on the cycle done is high (state IDLE) is accepted normally.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs zero; no done pulse.
- k_ready is ignored while k_valid=0.

Test Plan:
1. Reset, then start with x=F0CCAAF556678F, k_ready=1:
   - Cycle+1: k_valid=1, idx=15, k=CB3D8B0E17F5.
   - Next cycle: idx=14, k=BF918D3D3F0A.
   - 16th key: idx=0, k=1B02EFFC7072.
   - Next cycle: done=1, busy=0, k_valid=0.
2. Same key with k_ready toggled pseudo-randomly:
   - k/idx hold while k_ready=0.
   - Exactly 16 keys are transferred, in the same order and values as scenario 1.
3. Assert start with a different x during GEN at idx=9 -> sequence continues unchanged to idx=0; no reload occurs.
4. Assert rst low at idx=7, mid-cycle, asynchronously -> outputs go to zero immediately. After release with start, x=F0CCAAF556678F: first key is again CB3D8B0E17F5 with idx=15.
5. Back-to-back: start asserted in the done cycle -> the second sequence begins the next cycle with idx=15. Cross-check all 16 keys against the encryption key_schedule outputs in reverse order.
6. x = all-ones and x = 0000000FFFFFFF -> every k equals PC2 of the constant halves, confirming the rotation stays within each 28-bit half.
